seg7_scan_ctrl: RTL

//  Bus-programmable scan scheduler for the multiplexed 7-segment display.

---
 rtl/seg7_scan_ctrl_pkg.sv | 20 ++
 rtl/seg7_scan_ctrl_prescale.sv | 28 ++
 rtl/seg7_scan_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/seg7_scan_ctrl_pkg.sv
// rtl/seg7_scan_ctrl_pkg.sv - register map, CTRL field positions and scan FSM states
package seg7_scan_ctrl_pkg;

   localparam logic [31:0] CTRL_OFS   = 32'd0;
   localparam logic [31:0] PERIOD_OFS = 32'd1;

   localparam int SCAN_EN_BIT = 0;
   localparam int BRIGHT_LSB  = 4;
   localparam int MASK_LSB    = 8;

   localparam logic [3:0] LAST_SLOT = 4'd15;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GUARD = 2'd1,
      ST_ON    = 2'd2,
      ST_OFF   = 2'd3
   } scan_state_t;

endpackage

// File: rtl/seg7_scan_ctrl_prescale.sv
// rtl/seg7_scan_ctrl_prescale.sv - slot prescaler: down-counter, strobe at zero, reload on strobe or restart
module seg7_scan_ctrl_prescale #(
   parameter int PWIDTH  = 16,
   parameter int RST_VAL = 1023
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              restart,
   input  logic [PWIDTH-1:0] period,
   output logic              strobe
);

   logic [PWIDTH-1:0] cnt_q, cnt_d;

   // Restart reloads the full period so the first slot after enabling is as long as any other.
   always_comb begin
      cnt_d = cnt_q - 1'b1;
      if (restart || cnt_q == '0) cnt_d = period;
   end

   assign strobe = (cnt_q == '0) && !restart;

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= PWIDTH'(RST_VAL);
      else       cnt_q <= cnt_d;
   end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - multiplexed 7-segment scan scheduler with guard slot and PWM brightness
module seg7_scan_ctrl
   import seg7_scan_ctrl_pkg::*;
#(
   parameter logic [31:0] BASE       = 32'h20,
   parameter int          NDIGITS    = 4,
   parameter int          PWIDTH     = 16,
   parameter int          PERIOD_RST = 1023
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic               rw,
   input  logic [31:0]        addr,
   input  logic [31:0]        data,
   output logic [NDIGITS-1:0] an,
   output logic [2:0]         digit,
   output logic               blank,
   output logic               tick
);

   logic               scan_en_q, scan_en_d;
   logic [3:0]         bright_q, bright_d;
   logic [NDIGITS-1:0] mask_q, mask_d;
   logic [PWIDTH-1:0]  period_q, period_d;
   scan_state_t        state_q, state_d;
   logic [3:0]         slot_q, slot_d;
   logic [2:0]         digit_q, digit_d;
   logic [NDIGITS-1:0] an_q, an_d;
   logic               blank_q, blank_d;
   logic               tick_q, tick_d;
   logic               wr, restart, strobe;
   logic               unused_data;

   assign unused_data = ^data;
   assign wr          = enable && rw;
   assign restart     = (state_q == ST_IDLE) || !scan_en_q;

   seg7_scan_ctrl_prescale #(
      .PWIDTH  (PWIDTH),
      .RST_VAL (PERIOD_RST)
   ) u_prescale (
      .clk     (clk),
      .reset   (reset),
      .restart (restart),
      .period  (period_q),
      .strobe  (strobe)
   );

   always_comb begin
      scan_en_d = scan_en_q;
      bright_d  = bright_q;
      mask_d    = mask_q;
      period_d  = period_q;
      if (wr && addr == BASE + CTRL_OFS) begin
         scan_en_d = data[SCAN_EN_BIT];
         bright_d  = data[BRIGHT_LSB +: 4];
         mask_d    = data[MASK_LSB +: NDIGITS];
      end
      if (wr && addr == BASE + PERIOD_OFS) period_d = data[PWIDTH-1:0];
   end

   always_comb begin
      state_d = state_q;
      slot_d  = slot_q;
      digit_d = digit_q;
      tick_d  = 1'b0;
      if (!scan_en_q) begin
         state_d = ST_IDLE;
         slot_d  = 4'd0;
         digit_d = 3'd0;
      end else if (state_q == ST_IDLE) begin
         state_d = ST_GUARD;
         slot_d  = 4'd0;
         digit_d = 3'd0;
      end else begin
         if (strobe) slot_d = slot_q + 4'd1;
         if (strobe && slot_q == LAST_SLOT) begin
            state_d = ST_GUARD;
            digit_d = (digit_q == 3'(NDIGITS - 1)) ? 3'd0 : digit_q + 3'd1;
            tick_d  = 1'b1;
         end else begin
            case (state_q)
               ST_GUARD: if (strobe) state_d = (bright_q != 4'd0) ? ST_ON : ST_OFF;
               // bright is compared live so lowering it mid-frame cuts the lit period short.
               ST_ON: if (slot_q > bright_q || (strobe && slot_q == bright_q)) state_d = ST_OFF;
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      an_d = '1;
      for (int i = 0; i < NDIGITS; i++)
         an_d[i] = !(state_d == ST_ON && digit_d == 3'(i) && mask_q[i]);
      blank_d = &an_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         scan_en_q <= 1'b1;
         bright_q  <= 4'd15;
         mask_q    <= '1;
         period_q  <= PWIDTH'(PERIOD_RST);
         state_q   <= ST_IDLE;
         slot_q    <= 4'd0;
         digit_q   <= 3'd0;
         an_q      <= '1;
         blank_q   <= 1'b1;
         tick_q    <= 1'b0;
      end else begin
         scan_en_q <= scan_en_d;
         bright_q  <= bright_d;
         mask_q    <= mask_d;
         period_q  <= period_d;
         state_q   <= state_d;
         slot_q    <= slot_d;
         digit_q   <= digit_d;
         an_q      <= an_d;
         blank_q   <= blank_d;
         tick_q    <= tick_d;
      end
   end

   assign an    = an_q;
   assign digit = digit_q;
   assign blank = blank_q;
   assign tick  = tick_q;

endmodule
